// File: rtl/logic_unit_acc_pkg.sv
// Shared definitions for the logic unit: op encodings used by the core and the top.
package logic_unit_acc_pkg;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_OR     = 3'd1;
  localparam logic [2:0] OP_XOR    = 3'd2;
  localparam logic [2:0] OP_NAND   = 3'd3;
  localparam logic [2:0] OP_NOR    = 3'd4;
  localparam logic [2:0] OP_XNOR   = 3'd5;
  localparam logic [2:0] OP_PASS_X = 3'd6;
  localparam logic [2:0] OP_NOT_X  = 3'd7;

endpackage

// File: rtl/logic_unit_acc_core.sv
// WIDTH-bit bitwise gate f(op,x,y); purely combinational, zero latency.
// No handshake of its own: the caller decides when the result is used.
module logic_op_core
  import logic_unit_acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] f
);

  always_comb begin
    f = '0;
    case (op)
      OP_AND:    f = x & y;
      OP_OR:     f = x | y;
      OP_XOR:    f = x ^ y;
      OP_NAND:   f = ~(x & y);
      OP_NOR:    f = ~(x | y);
      OP_XNOR:   f = ~(x ^ y);
      OP_PASS_X: f = x;
      default:   f = ~x;
    endcase
  end

endmodule

// File: rtl/logic_unit_acc.sv
// Registered bitwise logic unit with burst accumulate and reduction flags; latency 1 cycle.
// in_ready drops only while a result is held and the consumer is not taking it.
module logic_unit_acc
  import logic_unit_acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_first,
  input  logic             acc_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_any,
  output logic             out_all,
  output logic             out_parity,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             accept;
  logic             produce;
  logic             restart;
  logic [WIDTH-1:0] core_x;
  logic [WIDTH-1:0] core_y;
  logic [WIDTH-1:0] core_f;
  logic [WIDTH-1:0] combined;
  logic [WIDTH-1:0] acc_q;
  logic             burst_open;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] base_cnt;
  logic [CNT_W-1:0] inc_cnt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign produce  = accept && (!acc_en || acc_last);

  // In accumulate mode the running value takes the x slot and the new beat the y slot.
  assign core_x = acc_en ? acc_q : a;
  assign core_y = acc_en ? a : b;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op (op),
    .x  (core_x),
    .y  (core_y),
    .f  (core_f)
  );

  // acc_first on an open burst silently drops it and seeds a fresh one.
  assign restart  = acc_first || !burst_open;
  assign combined = (acc_en && restart) ? a : core_f;
  assign base_cnt = restart ? '0 : cnt_q;
  assign inc_cnt  = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      burst_open <= 1'b0;
      cnt_q      <= '0;
    end else if (accept && acc_en) begin
      if (acc_last) begin
        acc_q      <= '0;
        burst_open <= 1'b0;
        cnt_q      <= '0;
      end else begin
        acc_q      <= combined;
        burst_open <= 1'b1;
        cnt_q      <= inc_cnt;
      end
    end
  end

  // A new result overwrites a result being handed off in the same edge, so no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out        <= '0;
      out_any    <= 1'b0;
      out_all    <= 1'b0;
      out_parity <= 1'b0;
      beat_cnt   <= '0;
    end else if (produce) begin
      out_valid  <= 1'b1;
      out        <= combined;
      out_any    <= |combined;
      out_all    <= &combined;
      out_parity <= ^combined;
      beat_cnt   <= acc_en ? inc_cnt : CNT_ONE;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_unit_acc.sv
// Directed-vector bench for logic_unit_acc; expected results queue in a scoreboard drained by a monitor.
module tb_logic_unit_acc;
  import logic_unit_acc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       acc_en;
  logic       acc_first;
  logic       acc_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       out_any;
  logic       out_all;
  logic       out_parity;
  logic [3:0] beat_cnt;

  typedef struct {
    logic [7:0] res;
    logic       any;
    logic       all;
    logic       par;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   w;

  always #5 clk = ~clk;

  logic_unit_acc #(.WIDTH(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .acc_en     (acc_en),
    .acc_first  (acc_first),
    .acc_last   (acc_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .out_any    (out_any),
    .out_all    (out_all),
    .out_parity (out_parity),
    .beat_cnt   (beat_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_res(input logic [7:0] r, input logic any, input logic all,
                            input logic par, input logic [3:0] cnt);
    exp_t e;
    e.res = r; e.any = any; e.all = all; e.par = par; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Offers one beat and returns after the edge that accepts it.
  task automatic send(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb,
                      input logic en, input logic first, input logic last, output int waited);
    op = o; a = va; b = vb; acc_en = en; acc_first = first; acc_last = last;
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every output handshake must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got out=%0h beat_cnt=%0h, required no output", out, beat_cnt);
        end else begin
          e = sb.pop_front();
          chk("out", 32'(out), 32'(e.res));
          chk("out_any", 32'(out_any), 32'(e.any));
          chk("out_all", 32'(out_all), 32'(e.all));
          chk("out_parity", 32'(out_parity), 32'(e.par));
          chk("beat_cnt", 32'(beat_cnt), 32'(e.cnt));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; op = '0; acc_en = 0; acc_first = 0; acc_last = 0;

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      acc_en = 1'($urandom); acc_first = 1'($urandom); acc_last = 1'($urandom);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out", 32'(out), 32'h00);
      chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_no_out", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Single ops.
    expect_res(8'hAF, 1, 0, 0, 4'd1);
    send(OP_OR, 8'hA5, 8'h0F, 0, 0, 0, w);
    expect_res(8'h00, 0, 0, 0, 4'd1);
    send(OP_NAND, 8'hFF, 8'hFF, 0, 0, 0, w);
    @(negedge clk);

    // Backpressure: first result held, second beat stalls until released.
    @(posedge clk); #1;
    out_ready = 1'b0;
    expect_res(8'h03, 1, 0, 0, 4'd1);
    send(OP_OR, 8'h01, 8'h02, 0, 0, 0, w);
    expect_res(8'h30, 1, 0, 0, 4'd1);
    fork
      send(OP_OR, 8'h10, 8'h20, 0, 0, 0, w);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_hold_out", 32'(out), 32'h03);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    chk("stall_valid_after_swap", 32'(out_valid), 32'd1);
    @(negedge clk);
    @(posedge clk); #1;
    chk("drop_after_consume", 32'(out_valid), 32'd0);

    // OR burst: no output until the last beat.
    send(OP_AND, 8'h01, 8'h00, 1, 1, 0, w);
    send(OP_OR, 8'h04, 8'h00, 1, 0, 0, w);
    chk("burst_no_out", 32'(out_valid), 32'd0);
    expect_res(8'h85, 1, 0, 1, 4'd3);
    send(OP_OR, 8'h80, 8'h00, 1, 0, 1, w);

    // Reset mid-burst, then a last beat without first must start from scratch.
    send(OP_XOR, 8'h0F, 8'h00, 1, 1, 0, w);
    send(OP_XOR, 8'hF0, 8'h00, 1, 0, 0, w);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    expect_res(8'h3C, 1, 0, 0, 4'd1);
    send(OP_XOR, 8'h3C, 8'h00, 1, 0, 1, w);

    // acc_first on an open burst discards the earlier beats.
    send(OP_XOR, 8'hAA, 8'h00, 1, 1, 0, w);
    send(OP_XOR, 8'h55, 8'h00, 1, 0, 0, w);
    send(OP_XOR, 8'h12, 8'h00, 1, 1, 0, w);
    expect_res(8'h26, 1, 0, 1, 4'd2);
    send(OP_XOR, 8'h34, 8'h00, 1, 0, 1, w);

    // 17-beat burst: beat count saturates at 15.
    send(OP_OR, 8'h01, 8'h00, 1, 1, 0, w);
    for (int i = 0; i < 15; i++) send(OP_OR, 8'h01, 8'h00, 1, 0, 0, w);
    expect_res(8'h01, 1, 0, 1, 4'd15);
    send(OP_OR, 8'h01, 8'h00, 1, 0, 1, w);
    @(negedge clk);
    @(posedge clk); #1;

    // Streaming: back-to-back single beats never stall.
    expect_res(8'h30, 1, 0, 0, 4'd1);
    send(OP_AND, 8'hF0, 8'h3C, 0, 0, 0, w);
    chk("stream_wait0", 32'(w), 32'd0);
    expect_res(8'hF0, 1, 0, 0, 4'd1);
    send(OP_XOR, 8'hFF, 8'h0F, 0, 0, 0, w);
    chk("stream_wait1", 32'(w), 32'd0);
    expect_res(8'hFF, 1, 1, 0, 4'd1);
    send(OP_NOR, 8'h00, 8'h00, 0, 0, 0, w);
    chk("stream_wait2", 32'(w), 32'd0);
    expect_res(8'hFE, 1, 0, 1, 4'd1);
    send(OP_XNOR, 8'h00, 8'h01, 0, 0, 0, w);
    chk("stream_wait3", 32'(w), 32'd0);
    expect_res(8'h81, 1, 0, 0, 4'd1);
    send(OP_PASS_X, 8'h81, 8'h7E, 0, 0, 0, w);
    chk("stream_valid_held", 32'(out_valid), 32'd1);
    expect_res(8'hA5, 1, 0, 0, 4'd1);
    send(OP_NOT_X, 8'h5A, 8'hFF, 0, 0, 0, w);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
